// File: rtl/alu_pkg.sv
// Shared encodings for the MIPS ALU control and multiply/divide unit.
// ALUOp, funct and ALUCtr codes, select encodings and sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_BNE   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b1010;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_XOR   = 4'b1100;
  localparam logic [3:0] OP_RTYPE = 4'b1111;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBF  = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] ASEL_RS    = 2'b00;
  localparam logic [1:0] ASEL_SHAMT = 2'b01;
  localparam logic [1:0] ASEL_LUI   = 2'b10;

  localparam logic [1:0] HILO_ALU = 2'b00;
  localparam logic [1:0] HILO_HI  = 2'b01;
  localparam logic [1:0] HILO_LO  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_ctrl_mdu_md_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring step per RUN cycle,
// sign correction and HI/LO write in FIX. i_mode = funct[1:0] (bit1 divide, bit0 unsigned).
module md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output md_state_e        o_state,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          r_state, w_next;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand, r_hi, r_lo;
  logic               r_div, r_neg_q, r_neg_r, r_b_zero;

  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_step, w_prod_fix;
  logic [WIDTH-1:0]   w_quo, w_rem, w_hi, w_lo;

  assign w_a_neg = ~i_mode[0] & i_a[WIDTH-1];
  assign w_b_neg = ~i_mode[0] & i_b[WIDTH-1];
  assign w_abs_a = w_a_neg ? -i_a : i_a;
  assign w_abs_b = w_b_neg ? -i_b : i_b;

  // Product register doubles as {remainder, quotient} during divide.
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_rem_sh  = r_prod[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_mcand});
  assign w_step    = r_div ?
      {(w_ge ? (w_rem_sh[WIDTH-1:0] - r_mcand) : w_rem_sh[WIDTH-1:0]), r_prod[WIDTH-2:0], w_ge} :
      {w_mul_sum, r_prod[WIDTH-1:1]};

  assign w_prod_fix = r_neg_q ? -r_prod : r_prod;
  assign w_quo      = r_prod[WIDTH-1:0];
  assign w_rem      = r_prod[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo = w_prod_fix[WIDTH-1:0];
    if (r_div) begin
      w_hi = r_neg_r ? -w_rem : w_rem;
      w_lo = r_b_zero ? '1 : (r_neg_q ? -w_quo : w_quo);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (r_count == CNT_W'(WIDTH-1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (i_start) begin
          r_count  <= '0;
          r_prod   <= {{WIDTH{1'b0}}, w_abs_a};
          r_mcand  <= w_abs_b;
          r_div    <= i_mode[1];
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg;
          r_b_zero <= (i_b == '0);
        end
        RUN: begin
          r_prod  <= w_step;
          r_count <= r_count + 1'b1;
        end
        FIX: begin
          r_hi <= w_hi;
          r_lo <= w_lo;
        end
        default: ;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_done  = (r_state == FIX);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// MIPS ALU control: combinational {ALUOp, funct} decode plus the HI/LO
// multiply/divide sequencer and the pipeline stall it raises.
module alu_ctrl_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [CTR_W-1:0] alu_ctr,
  output logic [1:0]       asel,
  output logic             jr,
  output logic [1:0]       hilo_rd,
  output logic             illegal,
  output logic             stall,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [3:0] w_op, w_ctr;
  logic [1:0] w_asel, w_hilo;
  logic       w_jr, w_ill, w_md_op, w_start, w_done;
  md_state_e  w_state;

  assign w_op = 4'(alu_op);

  always_comb begin
    w_ctr   = ALU_ADD;
    w_asel  = ASEL_RS;
    w_jr    = 1'b0;
    w_hilo  = HILO_ALU;
    w_ill   = 1'b0;
    w_md_op = 1'b0;
    case (w_op)
      OP_ADD:   w_ctr = ALU_ADD;
      OP_SUB:   w_ctr = ALU_SUB;
      OP_OR:    w_ctr = ALU_OR;
      OP_SLT:   w_ctr = ALU_SLT;
      OP_BNE:   w_ctr = ALU_SUB;
      OP_AND:   w_ctr = ALU_AND;
      OP_XOR:   w_ctr = ALU_XOR;
      OP_LUI: begin
        w_ctr  = ALU_SLL;
        w_asel = ASEL_LUI;
      end
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  w_ctr = ALU_ADD;
          FN_ADDU: w_ctr = ALU_ADDU;
          FN_SUBF: w_ctr = ALU_SUB;
          FN_AND:  w_ctr = ALU_AND;
          FN_OR:   w_ctr = ALU_OR;
          FN_XOR:  w_ctr = ALU_XOR;
          FN_SLT:  w_ctr = ALU_SLT;
          FN_SLL:  begin w_ctr = ALU_SLL; w_asel = ASEL_SHAMT; end
          FN_SRL:  begin w_ctr = ALU_SRL; w_asel = ASEL_SHAMT; end
          FN_SRA:  begin w_ctr = ALU_SRA; w_asel = ASEL_SHAMT; end
          FN_JR:   w_jr = 1'b1;
          FN_MFHI: w_hilo = HILO_HI;
          FN_MFLO: w_hilo = HILO_LO;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: w_md_op = 1'b1;
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_start = valid_in & w_md_op;

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_mode  (funct[1:0]),
    .i_a     (op_a),
    .i_b     (op_b),
    .o_state (w_state),
    .o_done  (w_done),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  // Low in FIX so the held md instruction retires as HI/LO are written.
  assign stall   = ((w_state == IDLE) & w_start) | (w_state == RUN);
  assign md_busy = (w_state != IDLE) | w_done;

  assign alu_ctr = CTR_W'(w_ctr);
  assign asel    = w_asel;
  assign jr      = w_jr;
  assign hilo_rd = w_hilo;
  assign illegal = w_ill;

endmodule
